// File: rtl/victory_animator.sv
// Victory-display sequencer for the tug-of-war LED bar: blinks the winner's end,
// sweeps a single light toward the winner, then loops or holds until cleared.
module victory_animator #(
    parameter int unsigned N_LEDS     = 7,
    parameter int unsigned WIN_WIDTH  = 3,
    parameter int unsigned BLINKS     = 2,
    parameter int unsigned HOLD_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              winner_right,
    input  logic              repeat_en,
    input  logic              clear,
    input  logic [N_LEDS-1:0] score,
    output logic [N_LEDS-1:0] victory_led,
    output logic              active,
    output logic              done
);

    localparam int unsigned BLINK_FRAMES = 2 * BLINKS;
    localparam int unsigned FRAMES       = (BLINK_FRAMES > N_LEDS) ? BLINK_FRAMES : N_LEDS;
    localparam int unsigned FW           = $clog2(FRAMES);
    localparam int unsigned HW           = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [FW-1:0] LAST_BLINK = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] LAST_SWEEP = FW'(N_LEDS - 1);
    localparam logic [HW-1:0] LAST_HOLD  = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLINK = 2'd1,
        S_SWEEP = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          state;
    logic            side_right;
    logic [FW-1:0]   frame;
    logic [HW-1:0]   hold_cnt;
    logic            frame_end_c;

    // Block of WIN_WIDTH lit LEDs at the winner's end of the bar.
    function automatic logic [N_LEDS-1:0] win_mask(input logic right);
        return right ? ({N_LEDS{1'b1}} >> (N_LEDS - WIN_WIDTH))
                     : ({N_LEDS{1'b1}} << (N_LEDS - WIN_WIDTH));
    endfunction

    // Single light travelling from the loser's end toward the winner's end.
    function automatic logic [N_LEDS-1:0] sweep_mask(input logic right, input logic [FW-1:0] k);
        return right ? (N_LEDS'(1) << (N_LEDS - 1 - 32'(k)))
                     : (N_LEDS'(1) << k);
    endfunction

    assign frame_end_c = tick && (hold_cnt == LAST_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            side_right  <= 1'b0;
            frame       <= '0;
            hold_cnt    <= '0;
            victory_led <= '0;
            active      <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state       <= S_BLINK;
                side_right  <= winner_right;
                frame       <= '0;
                hold_cnt    <= '0;
                victory_led <= win_mask(winner_right);
                active      <= 1'b1;
            end else if (clear) begin
                state       <= S_IDLE;
                frame       <= '0;
                hold_cnt    <= '0;
                victory_led <= score;
                active      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        victory_led <= score;
                    end
                    S_BLINK: begin
                        if (tick) begin
                            hold_cnt <= frame_end_c ? '0 : hold_cnt + HW'(1);
                        end
                        if (frame_end_c) begin
                            if (frame == LAST_BLINK) begin
                                state       <= S_SWEEP;
                                frame       <= '0;
                                victory_led <= sweep_mask(side_right, '0);
                            end else begin
                                frame       <= frame + FW'(1);
                                // Odd frames (next frame index has LSB set) are dark.
                                victory_led <= frame[0] ? win_mask(side_right) : '0;
                            end
                        end
                    end
                    S_SWEEP: begin
                        if (tick) begin
                            hold_cnt <= frame_end_c ? '0 : hold_cnt + HW'(1);
                        end
                        if (frame_end_c) begin
                            frame <= '0;
                            if (frame != LAST_SWEEP) begin
                                frame       <= frame + FW'(1);
                                victory_led <= sweep_mask(side_right, frame + FW'(1));
                            end else if (repeat_en) begin
                                state       <= S_BLINK;
                                victory_led <= win_mask(side_right);
                            end else begin
                                state       <= S_HOLD;
                                victory_led <= win_mask(side_right);
                                active      <= 1'b0;
                                done        <= 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        victory_led <= win_mask(side_right);
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
